// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART TX FIFO, RX holding register and sticky halt flag.
// Defining MEM_IO_CLKCNT_EN adds a free-running 32-bit clock counter readable at 0x30004-0x30007.
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        halted,
    output logic        tx_overflow
);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TX_FIFO_DEPTH);
    localparam logic [PTR_W:0] NEAR_CNT = (PTR_W+1)'(TX_FIFO_DEPTH - 2);
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CTRL = 18'h30004;
`ifdef MEM_IO_CLKCNT_EN
    localparam logic [17:0] IO_CNT1 = 18'h30005;
    localparam logic [17:0] IO_CNT2 = 18'h30006;
    localparam logic [17:0] IO_CNT3 = 18'h30007;
`endif

    logic [7:0]            ram  [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]            fifo [0:TX_FIFO_DEPTH-1];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic                  rx_full;
    logic [7:0]            rx_byte;

    logic [17:0]           bus_a;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic                  is_io;
    logic                  bus_rd;
    logic                  bus_wr;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  rx_pop;
    logic [7:0]            push_data;
    logic [7:0]            io_rd_data;
    logic                  unused_hi_addr;

    assign bus_a          = mem_a[17:0];
    assign ram_a          = mem_a[ADDR_WIDTH-1:0];
    assign unused_hi_addr = ^mem_a[31:18];
    assign is_io          = (bus_a[17:16] == 2'b11);
    assign bus_rd         = rdy_in && !mem_wr;
    assign bus_wr         = rdy_in && mem_wr;

    // The halt register doubles as a push of 0x00 so the UART sees the stop in stream order.
    assign push_req  = bus_wr && is_io &&
                       ((bus_a == IO_UART && mem_dout != 8'h00) || bus_a == IO_CTRL);
    assign push_data = (bus_a == IO_CTRL) ? 8'h00 : mem_dout;
    assign pop       = tx_valid && tx_ready;
    assign push_ok   = push_req && (count != FULL_CNT || pop);
    assign rx_pop    = bus_rd && is_io && (bus_a == IO_UART) && rx_full;

    assign tx_valid       = (count != '0);
    assign tx_data        = fifo[rd_ptr];
    assign io_buffer_full = (count >= NEAR_CNT);

`ifdef MEM_IO_CLKCNT_EN
    logic [31:0] clk_cnt;
    logic [31:0] cnt_latch;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_cnt   <= '0;
            cnt_latch <= '0;
        end else begin
            clk_cnt <= clk_cnt + 32'd1;
            if (bus_rd && bus_a == IO_CTRL)
                cnt_latch <= clk_cnt;
        end
    end
`endif

    always_comb begin
        io_rd_data = 8'h00;
        if (bus_a == IO_UART)
            io_rd_data = rx_full ? rx_byte : 8'h00;
`ifdef MEM_IO_CLKCNT_EN
        else if (bus_a == IO_CTRL)
            io_rd_data = clk_cnt[7:0];
        else if (bus_a == IO_CNT1)
            io_rd_data = cnt_latch[15:8];
        else if (bus_a == IO_CNT2)
            io_rd_data = cnt_latch[23:16];
        else if (bus_a == IO_CNT3)
            io_rd_data = cnt_latch[31:24];
`endif
    end

    // Storage arrays carry no reset so RAM contents survive rst_in.
    always_ff @(posedge clk_in) begin
        if (!rst_in && bus_wr && !is_io)
            ram[ram_a] <= mem_dout;
        if (!rst_in && push_ok)
            fifo[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
            halted      <= 1'b0;
            rx_full     <= 1'b0;
            rx_byte     <= 8'h00;
            mem_din     <= 8'h00;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            if (push_req && !push_ok)
                tx_overflow <= 1'b1;
            if (bus_wr && is_io && bus_a == IO_CTRL)
                halted <= 1'b1;
            // A fresh byte wins over a same-cycle read, which still returns the old one.
            if (rx_valid) begin
                rx_byte <= rx_data;
                rx_full <= 1'b1;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
            if (bus_rd)
                mem_din <= is_io ? io_rd_data : ram[ram_a];
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/array model of the responder.
module tb_mem_io_responder;
    localparam int          ADDR_WIDTH = 17;
    localparam int          DEPTH      = 8;
    localparam int unsigned RAM_BYTES  = 1 << ADDR_WIDTH;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        halted;
    logic        tx_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.ADDR_WIDTH(ADDR_WIDTH), .TX_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .halted(halted), .tx_overflow(tx_overflow)
    );

    // Reference model state: sparse RAM image, FIFO as a queue, plain flags and a cycle count.
    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q [$];
    logic [7:0]  exp_din = '0;
    bit          din_known = 0;
    bit          exp_halted = 0;
    bit          exp_ovf = 0;
    bit          rx_full_m = 0;
    logic [7:0]  rx_byte_m = '0;
    int unsigned cycles_m = 0;
    int unsigned latch_m = 0;
    bit          model_live = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rdy, input logic [31:0] addr, input bit wr,
                                 input logic [7:0] dout, input bit txr, input bit rxv, input logic [7:0] rxd);
        rst_in   = rst;
        rdy_in   = rdy;
        mem_a    = addr;
        mem_wr   = wr;
        mem_dout = dout;
        tx_ready = txr;
        rx_valid = rxv;
        rx_data  = rxd;
        @(negedge clk_in);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] d, input bit txr);
        applyStimulus(0, 1, addr, 1, d, txr, 0, 8'h00);
    endtask

    task automatic bus_read(input logic [31:0] addr, input bit txr);
        applyStimulus(0, 1, addr, 0, 8'h00, txr, 0, 8'h00);
    endtask

    task automatic idle(input bit txr);
        applyStimulus(0, 0, 32'h0, 0, 8'h00, txr, 0, 8'h00);
    endtask

    task automatic do_reset();
        applyStimulus(1, 0, 32'h0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    always @(posedge clk_in) begin : model_step
        int unsigned a;
        int unsigned ra;
        bit          io;
        bit          full_before;
        bit          popped;
        bit          rx_read;
        bit          want_push;
        logic [7:0]  pdata;
        if (rst_in) begin
            tx_q.delete();
            exp_din    = 8'h00;
            din_known  = 1;
            exp_halted = 0;
            exp_ovf    = 0;
            rx_full_m  = 0;
            rx_byte_m  = 8'h00;
            cycles_m   = 0;
            latch_m    = 0;
            model_live = 1;
        end else if (model_live) begin
            a           = mem_a % 32'h40000;
            ra          = mem_a % RAM_BYTES;
            io          = (a >= 32'h30000);
            rx_read     = 0;
            want_push   = 0;
            pdata       = 8'h00;
            full_before = (tx_q.size() == DEPTH);
            popped      = (tx_q.size() != 0) && tx_ready;
            if (rdy_in && mem_wr) begin
                if (!io)
                    ram_m[ra] = mem_dout;
                else if (a == 32'h30000 && mem_dout != 8'h00) begin
                    want_push = 1;
                    pdata     = mem_dout;
                end else if (a == 32'h30004) begin
                    want_push  = 1;
                    exp_halted = 1;
                end
            end
            if (rdy_in && !mem_wr) begin
                din_known = 1;
                if (!io) begin
                    if (ram_m.exists(ra))
                        exp_din = ram_m[ra];
                    else
                        din_known = 0;
                end else if (a == 32'h30000) begin
                    exp_din = rx_full_m ? rx_byte_m : 8'h00;
                    rx_read = 1;
`ifdef MEM_IO_CLKCNT_EN
                end else if (a == 32'h30004) begin
                    exp_din = 8'(cycles_m % 256);
                    latch_m = cycles_m;
                end else if (a >= 32'h30005 && a <= 32'h30007) begin
                    exp_din = 8'((latch_m >> (8 * (a - 32'h30004))) % 256);
`endif
                end else begin
                    exp_din = 8'h00;
                end
            end
            if (popped)
                void'(tx_q.pop_front());
            if (want_push) begin
                if (!full_before || popped)
                    tx_q.push_back(pdata);
                else
                    exp_ovf = 1;
            end
            if (rx_valid) begin
                rx_byte_m = rx_data;
                rx_full_m = 1;
            end else if (rx_read) begin
                rx_full_m = 0;
            end
            cycles_m++;
        end
    end

    always @(negedge clk_in) begin
        if (model_live) begin
            if (din_known)
                checkOutput("mem_din", 32'(mem_din), 32'(exp_din));
            checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0)
                checkOutput("tx_data", 32'(tx_data), 32'(tx_q[0]));
            checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(tx_q.size() >= DEPTH - 2));
            checkOutput("halted", 32'(halted), 32'(exp_halted));
            checkOutput("tx_overflow", 32'(tx_overflow), 32'(exp_ovf));
        end
    end

    logic [31:0] ram_pool [8] = '{32'h00100, 32'h00101, 32'h00000, 32'h1FFFF,
                                  32'h0ABCD, 32'h20100, 32'h10000, 32'h2FFFF};
    logic [31:0] io_pool [10] = '{32'h30000, 32'h30000, 32'h30000, 32'h30004, 32'h30005,
                                  32'h30006, 32'h30007, 32'h30001, 32'h30008, 32'h3FFFF};

    initial begin : driver
        logic [31:0] cnt_val;
        do_reset();
        do_reset();
        checkOutput("reset_mem_din", 32'(mem_din), 32'h0);
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("reset_io_full", 32'(io_buffer_full), 32'h0);
        checkOutput("reset_halted", 32'(halted), 32'h0);
        checkOutput("reset_overflow", 32'(tx_overflow), 32'h0);

        bus_write(32'h00100, 8'hA5, 0);
        bus_read(32'h00100, 0);
        checkOutput("ram_rd_A5", 32'(mem_din), 32'hA5);
        bus_write(32'h00200, 8'h11, 0);
        applyStimulus(1, 1, 32'h00200, 1, 8'h77, 0, 0, 8'h00);
        bus_read(32'h00200, 0);
        checkOutput("write_on_reset_dropped", 32'(mem_din), 32'h11);

        for (int k = 1; k <= 9; k++) begin
            bus_write(32'h30000, 8'h41, 0);
            if (k == 5) checkOutput("near_full_at5", 32'(io_buffer_full), 32'h0);
            if (k == 6) checkOutput("near_full_at6", 32'(io_buffer_full), 32'h1);
            if (k == 8) checkOutput("no_ovf_at8", 32'(tx_overflow), 32'h0);
        end
        checkOutput("ovf_at9", 32'(tx_overflow), 32'h1);
        bus_write(32'h30000, 8'h42, 1);
        checkOutput("full_push_pop_head", 32'(tx_data), 32'h41);
        checkOutput("full_push_pop_near", 32'(io_buffer_full), 32'h1);
        for (int j = 1; j <= 8; j++) begin
            idle(1);
            if (j == 6) checkOutput("drain_head_41", 32'(tx_data), 32'h41);
            if (j == 7) checkOutput("drain_last_42", 32'(tx_data), 32'h42);
        end
        checkOutput("drain_empty", 32'(tx_valid), 32'h0);

        do_reset();
        applyStimulus(0, 0, 32'h0, 0, 8'h00, 0, 1, 8'h37);
        bus_read(32'h30000, 0);
        checkOutput("rx_first_read", 32'(mem_din), 32'h37);
        bus_read(32'h30000, 0);
        checkOutput("rx_second_read", 32'(mem_din), 32'h00);
        applyStimulus(0, 0, 32'h0, 0, 8'h00, 0, 1, 8'h11);
        applyStimulus(0, 1, 32'h30000, 0, 8'h00, 0, 1, 8'h22);
        checkOutput("rx_collide_old", 32'(mem_din), 32'h11);
        bus_read(32'h30000, 0);
        checkOutput("rx_collide_new", 32'(mem_din), 32'h22);

        do_reset();
        bus_write(32'h30000, 8'h55, 0);
        bus_write(32'h30004, 8'h99, 0);
        checkOutput("halt_set", 32'(halted), 32'h1);
        checkOutput("halt_order_head", 32'(tx_data), 32'h55);
        idle(1);
        checkOutput("halt_zero_byte", 32'(tx_data), 32'h00);
        checkOutput("halt_zero_valid", 32'(tx_valid), 32'h1);
        bus_write(32'h0ABCD, 8'h3C, 1);
        bus_read(32'h0ABCD, 1);
        checkOutput("ram_after_halt", 32'(mem_din), 32'h3C);
        do_reset();
        checkOutput("halt_cleared", 32'(halted), 32'h0);

        for (int j = 1; j <= 99; j++)
            idle(0);
        bus_read(32'h30004, 0);
        cnt_val[7:0] = mem_din;
        bus_read(32'h30005, 0);
        cnt_val[15:8] = mem_din;
        bus_read(32'h30006, 0);
        cnt_val[23:16] = mem_din;
        bus_read(32'h30007, 0);
        cnt_val[31:24] = mem_din;
`ifdef MEM_IO_CLKCNT_EN
        checkOutput("clkcnt_value", cnt_val, 32'd99);
`else
        checkOutput("clkcnt_absent", cnt_val, 32'd0);
`endif

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] hi;
            logic [31:0] base;
            logic [31:0] addr;
            logic [7:0]  d;
            bit          wr;
            int          idx;
            hi  = $urandom();
            d   = 8'($urandom());
            wr  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 5) begin
                idx  = $urandom_range(0, 7);
                base = ram_pool[idx];
            end else begin
                idx  = $urandom_range(0, 9);
                base = io_pool[idx];
            end
            addr = {hi[31:18], base[17:0]};
            if (base == 32'h30004 && wr && $urandom_range(0, 9) != 0)
                wr = 0;
            if (base == 32'h30000 && $urandom_range(0, 3) == 0)
                d = 8'h00;
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0), addr, wr, d,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 8'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
